// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU feeding the accumulator: 1-cycle ops plus a WIDTH-cycle shift-add multiply
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] accumulatorIn,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_LD  = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, MULT} state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 carry_q, carry_d, zero_q, zero_d, done_q, done_d;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic [2*WIDTH-1:0]   prod_next;

    // Single-cycle datapath; SUB reuses the adder so carry means "no borrow".
    always_comb begin
        sum_w   = '0;
        alu_res = a_q;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum_w   = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
            end
            OP_SUB: begin
                sum_w   = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_LD:   alu_res = b_q;
            default: alu_res = a_q;
        endcase
    end

    // Multiplier bits are consumed LSB first out of b_q while the multiplicand shifts up.
    assign prod_next = prod_q + (b_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    a_d     = accumulatorIn;
                    b_d     = operand;
                    mcand_d = {{WIDTH{1'b0}}, accumulatorIn};
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = (opcode == OP_MUL) ? MULT : EXEC;
                end
            end
            EXEC: begin
                result_d = alu_res;
                carry_d  = alu_c;
                zero_d   = (alu_res == '0);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            MULT: begin
                prod_d  = prod_next;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = prod_next[WIDTH-1:0];
                    carry_d  = |prod_next[2*WIDTH-1:WIDTH];
                    zero_d   = (prod_next[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule
